// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - single-cycle instruction decoder with register file and operand read.
// Optional feature: define DECODE_WB_BYPASS_EN to forward same-cycle writeback data to operand reads.
module decode_stage #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instruction,
    input  logic              wb_en,
    input  logic [4:0]        wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        opcode,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        rd,
    output logic [4:0]        sa,
    output logic [5:0]        funct,
    output logic [15:0]       imm,
    output logic [DATA_W-1:0] imm_ext,
    output logic [25:0]       jaddr,
    output logic [1:0]        itype,
    output logic [DATA_W-1:0] rs_val,
    output logic [DATA_W-1:0] rt_val,
    output logic              halted
);

    localparam int          AW      = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam logic [31:0] NREGS_U = 32'(NREGS);

    typedef enum logic [1:0] {
        IT_R    = 2'd0,
        IT_J    = 2'd1,
        IT_HALT = 2'd2,
        IT_I    = 2'd3
    } itype_e;

    logic [DATA_W-1:0] regs [NREGS];
    logic              accept;
    logic              wb_ok;

    itype_e            d_itype;
    logic [4:0]        d_rs, d_rt, d_rd, d_sa;
    logic [5:0]        d_funct;
    logic [15:0]       d_imm;
    logic [DATA_W-1:0] d_imm_ext;
    logic [25:0]       d_jaddr;
    logic [DATA_W-1:0] d_rs_val, d_rt_val;
    logic [5:0]        f_op;

    assign in_ready = !halted && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign wb_ok    = wb_en && (wb_addr != 5'd0) && ({27'd0, wb_addr} < NREGS_U);
    assign f_op     = instruction[31:26];

    // r0 and out-of-range indices read as zero; bypass only matters for a real write.
    function automatic logic [DATA_W-1:0] rf_read(input logic [4:0] idx);
        logic [DATA_W-1:0] v;
        v = '0;
        if (idx != 5'd0 && {27'd0, idx} < NREGS_U) begin
            v = regs[idx[AW-1:0]];
`ifdef DECODE_WB_BYPASS_EN
            if (wb_ok && wb_addr == idx) begin
                v = wb_data;
            end
`endif
        end
        return v;
    endfunction

    always_comb begin
        d_itype   = IT_I;
        d_rs      = '0;
        d_rt      = '0;
        d_rd      = '0;
        d_sa      = '0;
        d_funct   = '0;
        d_imm     = '0;
        d_imm_ext = '0;
        d_jaddr   = '0;
        d_rs_val  = '0;
        d_rt_val  = '0;
        case (f_op)
            6'h00: begin
                d_itype  = IT_R;
                d_rs     = instruction[25:21];
                d_rt     = instruction[20:16];
                d_rd     = instruction[15:11];
                d_sa     = instruction[10:6];
                d_funct  = instruction[5:0];
                d_rs_val = rf_read(instruction[25:21]);
                d_rt_val = rf_read(instruction[20:16]);
            end
            6'h02: begin
                d_itype = IT_J;
                d_jaddr = instruction[25:0];
            end
            6'h3F: begin
                d_itype = IT_HALT;
            end
            default: begin
                d_itype  = IT_I;
                d_rs     = instruction[25:21];
                d_rt     = instruction[20:16];
                d_imm    = instruction[15:0];
                // Logical immediates (0x0C/0x0D) zero-extend; all others sign-extend.
                if (f_op == 6'h0C || f_op == 6'h0D) begin
                    d_imm_ext = DATA_W'(instruction[15:0]);
                end else begin
                    d_imm_ext = DATA_W'(signed'(instruction[15:0]));
                end
                d_rs_val = rf_read(instruction[25:21]);
                d_rt_val = rf_read(instruction[20:16]);
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            halted    <= 1'b0;
            opcode    <= '0;
            rs        <= '0;
            rt        <= '0;
            rd        <= '0;
            sa        <= '0;
            funct     <= '0;
            imm       <= '0;
            imm_ext   <= '0;
            jaddr     <= '0;
            itype     <= '0;
            rs_val    <= '0;
            rt_val    <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                opcode    <= f_op;
                rs        <= d_rs;
                rt        <= d_rt;
                rd        <= d_rd;
                sa        <= d_sa;
                funct     <= d_funct;
                imm       <= d_imm;
                imm_ext   <= d_imm_ext;
                jaddr     <= d_jaddr;
                itype     <= d_itype;
                rs_val    <= d_rs_val;
                rt_val    <= d_rt_val;
                if (d_itype == IT_HALT) begin
                    halted <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Writeback is independent of the handshake and of halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_ok) begin
            regs[wb_addr[AW-1:0]] <= wb_data;
        end
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the register and operand width (minimum 16).
REQ-002 The block SHALL have parameter NREGS, default 32, meaning the number of architectural registers (power of 2, at most 32).
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  instruction word present.
- in_ready  output  1  decoder accepts the word this cycle.
- instruction  input  32  instruction word.
- wb_en  input  1  register write enable.
- wb_addr  input  5  write register index.
- wb_data  input  DATA_W  write data.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- opcode  output  6  instruction[31:26].
- rs, rt, rd, sa  output  5 each  register and shift fields.
- funct  output  6  function field.
- imm  output  16  raw immediate.
- imm_ext  output  DATA_W  extended immediate.
- jaddr  output  26  jump target field.
- itype  output  2  instruction class: R=0, J=1, HALT=2, I=3.
- rs_val, rt_val  output  DATA_W  register operands.
- halted  output  1  HALT has been accepted.

Function
REQ-004 The block SHALL accept an instruction when in_valid and in_ready are both high (a handshake).
REQ-005 in_ready SHALL equal !halted && (!out_valid || out_ready).
REQ-006 Latency SHALL be one cycle: the bundle for a word accepted at edge N is valid after edge N, with out_valid high.
REQ-007 out_valid SHALL clear on an out_ready handshake when no new word is accepted in the same cycle; a simultaneous accept SHALL replace the bundle with no bubble.
REQ-008 While out_valid is high and out_ready is low, every output SHALL hold stable, including rs_val and rt_val; operands are captured only at acceptance.
REQ-009 Class decode SHALL be: opcode 0x00 gives R, 0x02 gives J, 0x3F gives HALT, every other opcode gives I.
REQ-010 For R, the block SHALL drive rs, rt, rd, sa and funct from the word, and drive imm, imm_ext and jaddr as 0.
REQ-011 For J, the block SHALL drive jaddr = instruction[25:0] and drive all other fields and operands as 0.
REQ-012 For I, the block SHALL drive rs = [25:21], rt = [20:16] and imm = [15:0], and drive rd, sa, funct and jaddr as 0.
REQ-013 imm_ext SHALL be imm zero-extended for opcodes 0x0C and 0x0D, and sign-extended to DATA_W for all other I opcodes.
REQ-014 For HALT, the block SHALL drive itype = 2 with all fields 0, and set halted on the accepting edge.
REQ-015 halted SHALL remain set until reset, and no further word SHALL be accepted while it is set.
REQ-016 The register file SHALL hold NREGS x DATA_W entries, written on wb_en at the rising edge.
REQ-017 Writes with wb_addr >= NREGS or wb_addr = 0 SHALL be ignored.
REQ-018 Register 0 SHALL always read as 0, and reads with an index >= NREGS SHALL return 0.
REQ-019 wb writes SHALL proceed regardless of halted or stall state.

Reset
REQ-020 While rst_n is low, all of these SHALL be 0: registers, out_valid, halted and every bundle output.
REQ-021 in_ready SHALL be 1 after reset is released.
REQ-022 Reset asserted mid-stall SHALL discard the held bundle.

Configuration
REQ-023 With DECODE_WB_BYPASS_EN defined, a read of a register written in the same accept cycle SHALL return wb_data.
REQ-024 Without DECODE_WB_BYPASS_EN, that same read SHALL return the pre-write value.

Verification
REQ-025 Write r5 = 0x1234 via wb, then accept 0x00A52020 -> next cycle itype = 0, rs = 5, rt = 5, rd = 4, funct = 0x20, rs_val = rt_val = 0x1234.
REQ-026 Accept 0x2001FFFF -> itype = 3, imm_ext = 0xFFFFFFFF; accept 0x3001FFFF -> imm_ext = 0x0000FFFF.
REQ-027 Hold out_ready = 0 for 3 cycles after an accept while writing the source register -> in_ready = 0 and rs_val unchanged for all 3 cycles.
REQ-028 Write r3 = 7 in the same cycle as accepting a read of r3 -> rs_val = 7 with DECODE_WB_BYPASS_EN defined, old value without it.
REQ-029 Accept 0xFC000000, then offer further words -> halted = 1, in_ready stays 0, and a wb write to r0 still reads 0.
